ofifo_drain: RTL and testbench

OFIFO_DRAIN -- requirements
Module: ofifo_drain

---
 rtl/ofifo_drain_pkg.sv | 17 +
 rtl/ofifo_drain.sv | 135 +++++++++++++
 tb/tb_ofifo_drain.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofifo_drain_pkg.sv
// Shared FSM encoding and default geometry for the OFIFO drain /
// psum readback engine.
package ofifo_drain_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int ADDR_W  = 11;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ACC_RD,
    ACC_FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/ofifo_drain.sv
// Moves OFIFO words into psum SRAM, or streams stored psums back
// out to the SFU accumulate port.
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int addr_w  = ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [addr_w-1:0]        base_addr,
  input  logic [addr_w-1:0]        num_words,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  input  logic [psum_bw*col-1:0]   psum_in,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_w-1:0]        sram_addr,
  output logic [psum_bw*col-1:0]   sram_d,
  input  logic [psum_bw*col-1:0]   sram_q,
  output logic [psum_bw*col-1:0]   psum_accum_out,
  output logic                     accum,
  output logic                     busy,
  output logic                     done
);

  localparam logic [addr_w-1:0] one = addr_w'(1);

  state_t            state;
  logic [addr_w-1:0] addr;
  logic [addr_w-1:0] cnt;
  logic              flush;
  logic              rd_q;

  // cnt counts words still to be popped, so pops never overrun
  assign ofifo_rd = (state == DRAIN) && ofifo_valid && (cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      cnt            <= '0;
      flush          <= 1'b0;
      rd_q           <= 1'b0;
      sram_cen       <= 1'b1;
      sram_wen       <= 1'b1;
      sram_addr      <= '0;
      sram_d         <= '0;
      psum_accum_out <= '0;
      accum          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      sram_cen <= 1'b1;
      sram_wen <= 1'b1;
      done     <= 1'b0;
      // sram_q of a read lands one cycle later; register it here
      rd_q     <= ~sram_cen & sram_wen;
      accum    <= rd_q;
      if (rd_q)
        psum_accum_out <= sram_q;

      unique case (state)
        IDLE: begin
          if (start) begin
            addr <= base_addr;
            cnt  <= num_words;
            busy <= 1'b1;
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (mode) begin
              state     <= ACC_RD;
              sram_cen  <= 1'b0;
              sram_addr <= base_addr;
              addr      <= base_addr + one;
              cnt       <= num_words - one;
            end else begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (ofifo_rd) begin
            sram_d    <= psum_in;
            sram_cen  <= 1'b0;
            sram_wen  <= 1'b0;
            sram_addr <= addr;
            addr      <= addr + one;
            cnt       <= cnt - one;
          end else if (cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        ACC_RD: begin
          if (cnt != '0) begin
            sram_cen  <= 1'b0;
            sram_addr <= addr;
            addr      <= addr + one;
            cnt       <= cnt - one;
          end else begin
            state <= ACC_FLUSH;
            flush <= 1'b0;
          end
        end

        ACC_FLUSH: begin
          if (flush) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            flush <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofifo_drain.sv
// Directed bench for ofifo_drain: queue-based expectation model
// plus hand-computed literal checks.
module tb_ofifo_drain;
  import ofifo_drain_pkg::*;

  localparam int AW    = ADDR_W;
  localparam int DW    = COL * PSUM_BW;
  localparam int DEPTH = 1 << AW;

  localparam logic [DW-1:0] WA = {COL{16'h1111}};
  localparam logic [DW-1:0] WB = {COL{16'h2222}};
  localparam logic [DW-1:0] WC = {COL{16'h3333}};
  localparam logic [DW-1:0] WD = {COL{16'h4444}};
  localparam logic [DW-1:0] WE = {COL{16'h5a5a}};
  localparam logic [DW-1:0] WF = {COL{16'h6b6b}};
  localparam logic [DW-1:0] WG = {COL{16'h7c7c}};
  localparam logic [DW-1:0] WX = {COL{16'hdead}};
  localparam logic [DW-1:0] WY = {COL{16'hbeef}};
  localparam logic [DW-1:0] WZ = {COL{16'hcafe}};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_words = '0;
  logic          ofifo_valid = 1'b0;
  logic          ofifo_rd;
  logic [DW-1:0] psum_in = '0;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;
  logic [DW-1:0] psum_accum_out;
  logic          accum;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ofifo_drain dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .num_words(num_words),
    .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
    .psum_in(psum_in), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_d(sram_d), .sram_q(sram_q),
    .psum_accum_out(psum_accum_out), .accum(accum),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] src_q [$];
  int gap = 0;
  int holdoff = 0;

  wr_t           exp_wr [$];
  logic [DW-1:0] exp_acc [$];
  logic [AW-1:0] exp_rd [$];
  int            pop_cyc [$];
  int            rd_cyc [$];

  int n_accepted = 0;
  int n_done = 0;
  int n_pulse = 0;
  int n_pop = 0, n_wr = 0, n_rd = 0, n_acc = 0;
  int done_cyc = 0, start_cyc = 0;

  logic [AW-1:0] wr_addr_log [$];
  int            wr_cyc_log [$];
  logic [DW-1:0] acc_log [$];
  int            acc_cyc_log [$];
  int            rd_cyc_log [$];

  bit            did_pop, did_rd, did_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_d;

  task automatic chk(input bit ok, input string name,
                     input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // OFIFO source and SRAM array seen by the DUT
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (did_wr) mem[s_addr] = s_d;
      if (did_rd) sram_q = mem[s_addr];
      if (did_pop && src_q.size() > 0) begin
        void'(src_q.pop_front());
        holdoff = gap;
      end else if (holdoff > 0) begin
        holdoff--;
      end
    end
    ofifo_valid = (src_q.size() > 0) && (holdoff == 0);
    psum_in = (src_q.size() > 0) ? src_q[0] : '0;
  end

  // compare process
  always @(negedge clk) begin
    wr_t w;
    int p;
    bit act;
    logic [DW-1:0] e;
    logic [AW-1:0] ea;
    did_pop = 0;
    did_rd = 0;
    did_wr = 0;
    s_addr = sram_addr;
    s_d = sram_d;
    if (!reset) begin
      act = (n_accepted != n_done);
      chk(busy == act, "busy", DW'(busy), DW'(act));
      if (!act)
        chk({ofifo_rd, sram_cen, sram_wen, accum, done} == 5'b01100,
            "idle_quiet",
            DW'({ofifo_rd, sram_cen, sram_wen, accum, done}),
            DW'(5'b01100));
      if (ofifo_rd) begin
        chk(ofifo_valid, "pop_valid", DW'(ofifo_valid), DW'(1));
        did_pop = 1;
        n_pop++;
        pop_cyc.push_back(cyc);
      end
      if (!sram_cen && !sram_wen) begin
        did_wr = 1;
        n_wr++;
        wr_addr_log.push_back(sram_addr);
        wr_cyc_log.push_back(cyc);
        chk(exp_wr.size() > 0, "write_expected", DW'(sram_addr), DW'(0));
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          chk(sram_addr == w.a, "wr_addr", DW'(sram_addr), DW'(w.a));
          chk(sram_d == w.d, "wr_data", sram_d, w.d);
        end
        chk(pop_cyc.size() > 0, "wr_has_pop", DW'(cyc), DW'(0));
        if (pop_cyc.size() > 0) begin
          p = pop_cyc.pop_front();
          chk(cyc - p == 1, "wr_latency", DW'(cyc - p), DW'(1));
        end
      end
      if (!sram_cen && sram_wen) begin
        did_rd = 1;
        n_rd++;
        rd_cyc.push_back(cyc);
        rd_cyc_log.push_back(cyc);
        chk(exp_rd.size() > 0, "read_expected", DW'(sram_addr), DW'(0));
        if (exp_rd.size() > 0) begin
          ea = exp_rd.pop_front();
          chk(sram_addr == ea, "rd_addr", DW'(sram_addr), DW'(ea));
        end
      end
      if (accum) begin
        n_acc++;
        acc_log.push_back(psum_accum_out);
        acc_cyc_log.push_back(cyc);
        chk(exp_acc.size() > 0, "accum_expected", psum_accum_out, '0);
        if (exp_acc.size() > 0) begin
          e = exp_acc.pop_front();
          chk(psum_accum_out == e, "accum_data", psum_accum_out, e);
        end
        chk(rd_cyc.size() > 0, "accum_has_read", DW'(cyc), DW'(0));
        if (rd_cyc.size() > 0) begin
          p = rd_cyc.pop_front();
          chk(cyc - p == 2, "accum_latency", DW'(cyc - p), DW'(2));
        end
      end
      if (done) begin
        n_pulse++;
        done_cyc = cyc;
        chk(exp_wr.size() + exp_acc.size() + exp_rd.size() == 0,
            "done_pending",
            DW'(exp_wr.size() + exp_acc.size() + exp_rd.size()), DW'(0));
        if (act) n_done++;
      end
    end
  end

  task automatic do_start(input bit m, input int b, input int n);
    bit ok;
    logic [AW-1:0] a;
    @(negedge clk);
    #2;
    ok = (n_accepted == n_done);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        a = AW'(b + i);
        if (!m) begin
          exp_wr.push_back({a, src_q[i]});
        end else begin
          exp_rd.push_back(a);
          exp_acc.push_back(mem[a]);
        end
      end
    end
    start = 1'b1;
    mode = m;
    base_addr = AW'(b);
    num_words = AW'(n);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ok) n_accepted++;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    int k;
    n0 = n_pulse;
    k = 0;
    while (n_pulse == n0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(n_pulse != n0, "done_timeout", DW'(k), DW'(budget));
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_cyc_log.delete();
    acc_log.delete();
    acc_cyc_log.delete();
    rd_cyc_log.delete();
    n_pop = 0;
    n_wr = 0;
    n_rd = 0;
    n_acc = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = WX;
    mem[1] = WY;
    mem[2] = WZ;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk({sram_cen, sram_wen, ofifo_rd, accum, busy, done} == 6'b110000,
        "reset_ctrl",
        DW'({sram_cen, sram_wen, ofifo_rd, accum, busy, done}),
        DW'(6'b110000));
    chk(sram_addr == '0, "reset_addr", DW'(sram_addr), '0);
    chk(sram_d == '0, "reset_d", sram_d, '0);
    #1;
    reset = 1'b0;
    idle(2);

    // back-to-back drain
    clear_logs();
    #2;
    src_q = '{WA, WB, WC, WD};
    do_start(1'b0, 5, 4);
    wait_done(40);
    idle(2);
    chk(n_wr == 4, "drain_writes", DW'(n_wr), DW'(4));
    chk(wr_addr_log.size() == 4 && wr_addr_log[0] == 5 &&
        wr_addr_log[3] == 8, "drain_addrs",
        DW'(wr_addr_log.size() > 0 ? wr_addr_log[0] : '0), DW'(5));
    chk(wr_cyc_log.size() == 4 && wr_cyc_log[3] - wr_cyc_log[0] == 3,
        "drain_b2b",
        DW'(wr_cyc_log.size() == 4 ? wr_cyc_log[3] - wr_cyc_log[0] : -1),
        DW'(3));
    chk(mem[5] == WA, "mem5", mem[5], WA);
    chk(mem[8] == WD, "mem8", mem[8], WD);

    // drain with two-cycle OFIFO gaps
    clear_logs();
    gap = 2;
    #2;
    src_q = '{WE, WF, WG};
    do_start(1'b0, 20, 3);
    wait_done(60);
    idle(2);
    gap = 0;
    chk(n_pop == 3, "gap_pops", DW'(n_pop), DW'(3));
    chk(n_wr == 3, "gap_writes", DW'(n_wr), DW'(3));
    chk(wr_cyc_log.size() == 3 && wr_cyc_log[1] - wr_cyc_log[0] == 3,
        "gap_spacing",
        DW'(wr_cyc_log.size() == 3 ? wr_cyc_log[1] - wr_cyc_log[0] : -1),
        DW'(3));
    chk(mem[22] == WG, "mem22", mem[22], WG);

    // accumulate readback
    clear_logs();
    do_start(1'b1, 0, 3);
    wait_done(60);
    idle(2);
    chk(n_acc == 3, "acc_count", DW'(n_acc), DW'(3));
    chk(acc_log.size() == 3 && acc_log[0] == WX && acc_log[1] == WY &&
        acc_log[2] == WZ, "acc_values",
        acc_log.size() > 0 ? acc_log[0] : '0, WX);
    chk(acc_cyc_log.size() > 0 && rd_cyc_log.size() > 0 &&
        acc_cyc_log[0] - rd_cyc_log[0] == 2, "acc_first_latency",
        DW'(acc_cyc_log.size() > 0 && rd_cyc_log.size() > 0 ?
            acc_cyc_log[0] - rd_cyc_log[0] : -1), DW'(2));

    // address wrap
    clear_logs();
    #2;
    src_q = '{WB, WC};
    do_start(1'b0, DEPTH - 1, 2);
    wait_done(40);
    idle(2);
    chk(wr_addr_log.size() == 2 && wr_addr_log[0] == AW'(DEPTH - 1) &&
        wr_addr_log[1] == '0, "wrap_addrs",
        DW'(wr_addr_log.size() == 2 ? wr_addr_log[1] : '1), DW'(0));
    chk(mem[DEPTH-1] == WB, "mem_top", mem[DEPTH-1], WB);
    chk(mem[0] == WC, "mem0", mem[0], WC);

    // zero-length request
    clear_logs();
    do_start(1'b0, 9, 0);
    wait_done(10);
    idle(2);
    chk(done_cyc == start_cyc + 1, "zero_done_latency",
        DW'(done_cyc - start_cyc), DW'(1));
    chk(n_pop + n_wr + n_rd == 0, "zero_no_activity",
        DW'(n_pop + n_wr + n_rd), DW'(0));

    // start while busy is ignored
    clear_logs();
    #2;
    src_q = '{WD, WE, WF};
    do_start(1'b0, 30, 3);
    do_start(1'b1, 100, 2);
    wait_done(60);
    idle(2);
    chk(n_wr == 3 && n_rd == 0, "busy_start_ignored",
        DW'({n_wr[7:0], n_rd[7:0]}), DW'({8'd3, 8'd0}));

    // reset mid-drain
    clear_logs();
    #2;
    src_q = '{WA, WB, WC, WD, WE};
    do_start(1'b0, 40, 5);
    k = 0;
    while (n_wr < 2 && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(n_wr >= 2, "reset_wait_timeout", DW'(n_wr), DW'(2));
    #2;
    reset = 1'b1;
    #1;
    chk({sram_cen, sram_wen, ofifo_rd, accum, busy, done} == 6'b110000,
        "midreset_ctrl",
        DW'({sram_cen, sram_wen, ofifo_rd, accum, busy, done}),
        DW'(6'b110000));
    chk(sram_addr == '0, "midreset_addr", DW'(sram_addr), '0);
    chk(sram_d == '0, "midreset_d", sram_d, '0);
    chk(psum_accum_out == '0, "midreset_accum_out", psum_accum_out, '0);
    src_q.delete();
    exp_wr.delete();
    exp_rd.delete();
    exp_acc.delete();
    pop_cyc.delete();
    rd_cyc.delete();
    holdoff = 0;
    n_accepted = n_done;
    idle(2);
    #2;
    reset = 1'b0;
    idle(6);
    chk(n_wr == 2, "midreset_no_more_writes", DW'(n_wr), DW'(2));

    // engine usable again after reset
    clear_logs();
    #2;
    src_q = '{WG};
    do_start(1'b0, 7, 1);
    wait_done(30);
    idle(2);
    chk(mem[7] == WG, "post_reset_write", mem[7], WG);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
